// File: rtl/bram_fifo_pkg.sv
// Shared constants for the block-RAM FIFO: the WIDTH to SB_RAM40_4K mode map
// and helpers that turn a mode into the native lane width of one block.
package bram_fifo_pkg;

    localparam int SB_MODE_256X16 = 0;
    localparam int SB_MODE_512X8  = 1;
    localparam int SB_MODE_1024X4 = 2;
    localparam int SB_MODE_2048X2 = 3;

    // Narrowest native block geometry that still holds one word.
    // Anything wider than 16 bits is built from several 256x16 columns.
    function automatic int sb_mode(input int width);
        if (width <= 2)      return SB_MODE_2048X2;
        else if (width <= 4) return SB_MODE_1024X4;
        else if (width <= 8) return SB_MODE_512X8;
        else                 return SB_MODE_256X16;
    endfunction

    function automatic int sb_lane_w(input int mode);
        return 16 >> mode;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM, registered read with clock enable, no reset.
// Built as columns of native SB_RAM40_4K width so each column maps to one block.
module bram_sdp
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int MODE   = sb_mode(WIDTH);
    localparam int LANE_W = sb_lane_w(MODE);
    localparam int LANES  = (WIDTH + LANE_W - 1) / LANE_W;
    localparam int PAD_W  = LANES * LANE_W;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    logic [LANES-1:0][LANE_W-1:0] wdata_pad;
    logic [LANES-1:0][LANE_W-1:0] rdata_pad;
    logic [PAD_W-1:0]             rdata_flat;

    assign wdata_pad  = PAD_W'(wdata);
    assign rdata_flat = rdata_pad;
    assign rdata      = rdata_flat[WIDTH-1:0];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rd_q;

        // RDATA only moves when a read is issued; otherwise it holds.
        always_ff @(posedge CLK) begin
            if (we) mem[waddr] <= wdata_pad[l];
            if (re) rd_q <= mem[raddr];
        end

        assign rdata_pad[l] = rd_q;
    end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on an inferred block RAM. The RAM read register
// is the output stage; count covers both RAM contents and the presented word.
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  overflow
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0]      rdata;
    logic                  push, pop, rd_issue;
    logic [CW-1:0]         count_nxt, unread;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Words sitting in RAM that have not been moved to the output stage yet.
    // A word written this edge is not counted, so read/write never collide.
    assign unread   = count - CW'(out_valid);
    assign rd_issue = !RESET && (unread != '0) && (!out_valid || out_ready);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            in_ready    <= count_nxt < FULL_CNT;
            almost_full <= count_nxt >= AF_CNT;
            if (rd_issue)
                out_valid <= 1'b1;
            else if (pop)
                out_valid <= 1'b0;
            if (in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

    bram_sdp #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .CLK   (CLK),
        .we    (push && !RESET),
        .waddr (wr_ptr),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign out_data = out_valid ? rdata : '0;

endmodule

// File: tb/tb_bram_fifo.sv
// Randomised and directed bench for bram_fifo against a queue-based model.
module tb_bram_fifo;
    localparam int WIDTH      = 16;
    localparam int DEPTH_LOG2 = 8;
    localparam int DEPTH      = 256;
    localparam int AF_LEVEL   = 252;

    logic                  CLK = 1'b0;
    logic                  RESET = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      in_data = '0;
    logic                  in_ready, out_valid, almost_full, overflow;
    logic [WIDTH-1:0]      out_data;
    logic [DEPTH_LOG2:0]   count;

    int total = 0;
    int bad   = 0;

    // Model: queue of words held, whether the head is presented, ready, sticky overflow.
    logic [WIDTH-1:0] q[$];
    bit m_rdy  = 1'b0;
    bit m_pres = 1'b0;
    bit m_ovf  = 1'b0;

    always #5 CLK = ~CLK;

    bram_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .AF_LEVEL   (AF_LEVEL)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [WIDTH-1:0] exp_data;
        exp_data = m_pres ? q[0] : '0;
        chk("out_valid",   32'(out_valid),   32'(m_pres));
        chk("out_data",    32'(out_data),    32'(exp_data));
        chk("count",       32'(count),       32'(q.size()));
        chk("in_ready",    32'(in_ready),    32'(m_rdy));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    // One clock edge: drive inputs, advance the model with pre-edge state, check after.
    task automatic step(input bit rst, input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
        bit push, pop;
        RESET     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge CLK);
        if (rst) begin
            q.delete();
            m_rdy  = 1'b0;
            m_pres = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            push = iv && m_rdy;
            pop  = m_pres && ordy;
            if (iv && !m_rdy) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            // Any word already in the FIFO before this edge can be presented now.
            m_pres = q.size() > 0;
            if (push) q.push_back(d);
            m_rdy = q.size() < DEPTH;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, '0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single push: count at N+1, data at N+2, pop empties
        step(1'b0, 1'b1, 16'ha50f, 1'b0);
        chk("single_cnt", 32'(count), 32'd1);
        chk("single_early", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("single_vld", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'ha50f);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("single_popcnt", 32'(count), 32'd0);
        chk("single_popdat", 32'(out_data), 32'd0);

        // Fill to full, check almost_full boundary, overflow on push 257
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, WIDTH'(i), 1'b0);
            if (i == AF_LEVEL - 2) chk("af_below", 32'(almost_full), 32'd0);
            if (i == AF_LEVEL - 1) chk("af_at",    32'(almost_full), 32'd1);
        end
        chk("full_cnt", 32'(count), 32'd256);
        chk("full_rdy", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 16'hdead, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd256);
        drain();

        // Pop while full without a push: no overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, WIDTH'(i + 16'h100), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("full_pop_cnt", 32'(count), 32'd255);
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 16'h0bad, 1'b0);
        chk("refill_cnt", 32'(count), 32'd256);
        // Push and pop on the same edge when full: pop only, overflow set
        step(1'b0, 1'b1, 16'hbeef, 1'b1);
        chk("full_pp_cnt", 32'(count), 32'd255);
        chk("full_pp_ovf", 32'(overflow), 32'd1);
        drain();

        // Streaming 1000 words, out_ready held high
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1, WIDTH'(i), 1'b1);
            if (i >= 2) chk("stream_vld", 32'(out_valid), 32'd1);
        end
        drain();

        // Random traffic
        do_reset();
        for (int i = 0; i < 5000; i++)
            step(1'b0, 1'(($urandom >> 3) & 1), WIDTH'($urandom), 1'(($urandom >> 7) & 1));
        drain();

        // Reset mid-stream with count=100, push during reset edge is ignored
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, WIDTH'(i * 7), 1'b0);
        chk("mid_cnt", 32'(count), 32'd100);
        step(1'b1, 1'b1, 16'h7777, 1'b1);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("mid_rel_rdy", 32'(in_ready), 32'd1);
        chk("mid_rel_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("mid_fresh", 32'(out_data), 32'h1234);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
